bus_cycle_ctrl_8088: RTL and testbench
======================================

# bus_cycle_ctrl_8088

Parametrised bus-cycle controller for the 8088 verification environment. It converts single read/write requests on a valid/ready port into 8088-style T1–T2–T3–(Tw)*–T4 bus cycles, driving a multiplexed address/data bus. It generalises the previous bus interface in three ways: configurable address and data width, forced and target-requested wait states, and a bounded wait-state timeout. It sits between the stimulus/driver layer and the DUT bus pins; tristate resolution happens at the top level.

## Interface
- ADDR_W, 20, width of the bus address (Direction).
- DATA_W, 16, width of the data bus.
- MIN_WAIT, 0, number of Tw cycles always inserted, even if ready_pin is high.
- TIMEOUT, 15, maximum Tw cycles before the cycle is aborted. Must satisfy TIMEOUT ≥ MIN_WAIT and TIMEOUT ≥ 1.
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous reset, active-low.
- req_valid  in  1  a request is presented.
- req_ready  out  1  controller accepts a request this cycle.
- req_write  in  1  1 = write, 0 = read (same encoding as RD_WR).
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  read data; 0 for writes and for timeouts.
- rsp_timeout  out  1  qualifies rsp_valid: the cycle was aborted.
- Direction  out  ADDR_W  bus address.
- ale  out  1  address latch enable.
- RD_WR  out  1  bus direction, 1 = write.
- Data_out  out  DATA_W  write data toward the bus.
- Data_oe  out  1  output enable for Data_out.
- Data_in  in  DATA_W  resolved bus data.
- ready_pin  in  1  target ready, sampled in T3/Tw.
- busy  out  1  state ≠ IDLE.

## Operation
- States: IDLE, T1, T2, T3, TW, T4.
- Accept: a request is taken on an edge where req_valid && req_ready. At that edge the controller captures write, addr and wdata, clears wait_cnt and moves to T1.
- req_ready = (state==IDLE || state==T4) while reset is high. It is 0 while reset is low.
- T1: ale=1, Direction=addr, RD_WR=write. Next state is T2.
- T2: Direction and RD_WR held, ale=0. For writes, Data_oe=1 and Data_out=wdata. Next state is T3.
- T3/TW exit condition: ready_pin==1 && wait_cnt ≥ MIN_WAIT.
  - If the condition holds: a read captures Data_in into rsp_rdata; next state is T4 with timeout=0.
  - Else if wait_cnt == TIMEOUT: next state is T4 with timeout=1 and rdata=0.
  - Else: next state is TW and wait_cnt increments.
- Data_oe (writes only) stays asserted in T2, T3 and TW. It is 0 in T4, IDLE and T1. It is always 0 for reads.
- T4: rsp_valid=1 and rsp_timeout=flag for exactly this cycle; Direction and RD_WR still held.
  - With an accept in T4, next state is T1 (back-to-back).
  - Otherwise next state is IDLE.
- wait_cnt is $clog2(TIMEOUT+1) bits wide and saturates at TIMEOUT.
- Reset values, all registered:
  - Outputs: state=IDLE, Direction=0, RD_WR=0, Data_out=0, Data_oe=0, ale=0, rsp_valid=0, rsp_rdata=0, rsp_timeout=0, busy=0.
- Reset asserted mid-cycle:
  - Immediate return to IDLE; Data_oe drops asynchronously.
  - No rsp_valid is issued for the aborted request.

## Timing
- Accept at edge k: T1 in cycle k+1, T2 in k+2, T3 in k+3, T4 (rsp_valid) in k+4 + n, where n = number of Tw cycles.
- n = max(MIN_WAIT, cycles ready_pin is low). Capped at TIMEOUT, then abort.
- Read data is sampled at the edge ending the last T3/Tw cycle.
- Back-to-back throughput: one request per 4 cycles when no waits are inserted.
- ready_pin is ignored outside T3/TW.
- req_* inputs are ignored when req_ready=0.
- Only one transaction is outstanding; no queueing.

## Test plan
- Read, default parameters:
  - Stimulus: addr=20'hABCDE, ready_pin=1, Data_in=16'h1234.
  - Response: ale high one cycle; rsp_valid 4 cycles after accept; rsp_rdata=16'h1234; rsp_timeout=0; Data_oe never high.
- Write of 16'hBEEF to 20'h00010, ready_pin low for 3 cycles:
  - 3 Tw cycles; Data_oe high for 5 cycles with Data_out=16'hBEEF; rsp_valid at accept+7; RD_WR=1 from T1 through T4.
- MIN_WAIT=2, ready_pin tied high:
  - Exactly 2 Tw cycles; rsp_valid at accept+6.
- TIMEOUT=4, ready_pin tied low:
  - 4 Tw cycles, then T4 with rsp_timeout=1, rsp_rdata=0; next request accepted in T4.
- Back-to-back: req_valid held high for 3 reads, no waits:
  - Accepts every 4 cycles; rsp_valid pulses 4 cycles apart; ale pulses directly follow each T4.
- Reset pulled low during TW of a write:
  - Data_oe=0 and busy=0 without waiting for a clock edge; no rsp_valid.
  - After release, req_ready=1 and a new read completes normally.

Source files
------------

// File: rtl/bus_cycle_ctrl_8088.sv
// ---------------------------------------------------------------------------
// bus_cycle_ctrl_8088
//
// Turns single read/write requests on a valid/ready port into 8088-style
// T1-T2-T3-(Tw)*-T4 bus cycles on a multiplexed address/data bus. Wait
// states come from a forced minimum (MIN_WAIT) and from the target holding
// ready_pin low. A cycle that is still waiting after TIMEOUT Tw cycles is
// aborted and reported through rsp_timeout. Tristate resolution of the data
// bus is done by the surrounding top level.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake; req_write/addr/wdata describe it
//   rsp_valid             one-cycle completion pulse (in T4)
//   rsp_rdata             read data, 0 for writes and aborted cycles
//   rsp_timeout           qualifies rsp_valid: the cycle was aborted
//   Direction, ale, RD_WR address, address latch enable, 1 = write
//   Data_out, Data_oe     write data toward the bus and its output enable
//   Data_in, ready_pin    resolved bus data, target ready (used in T3/Tw)
//   busy                  a bus cycle is in progress
// ---------------------------------------------------------------------------
module bus_cycle_ctrl_8088 #(
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 16,
  parameter int MIN_WAIT = 0,
  parameter int TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] Direction,
  output logic              ale,
  output logic              RD_WR,
  output logic [DATA_W-1:0] Data_out,
  output logic              Data_oe,
  input  logic [DATA_W-1:0] Data_in,
  input  logic              ready_pin,
  output logic              busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_T1, S_T2, S_T3, S_TW, S_T4
  } state_e;

  state_e              state_q,       state_d;
  logic [CNT_W-1:0]    wait_cnt_q,    wait_cnt_d;
  logic                wr_q,          wr_d;
  logic [ADDR_W-1:0]   addr_q,        addr_d;
  logic [DATA_W-1:0]   wdata_q,       wdata_d;
  logic [DATA_W-1:0]   data_out_q,    data_out_d;
  logic                data_oe_q,     data_oe_d;
  logic                ale_q,         ale_d;
  logic                rsp_valid_q,   rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q,   rsp_rdata_d;
  logic                rsp_timeout_q, rsp_timeout_d;
  logic                busy_q,        busy_d;

  logic accept;
  logic wait_met;
  logic wait_expired;

  // Saturating wait counter increment; never runs past TIMEOUT.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (int'(v) < TIMEOUT) return v + 1'b1;
    return v;
  endfunction

  // Held low during reset so nothing is accepted while the bus is forced idle.
  assign req_ready    = reset && (state_q == S_IDLE || state_q == S_T4);
  assign accept       = req_valid && req_ready;
  assign wait_met     = (int'(wait_cnt_q) >= MIN_WAIT);
  assign wait_expired = (int'(wait_cnt_q) == TIMEOUT);

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    wr_d          = wr_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    data_out_d    = data_out_q;
    data_oe_d     = 1'b0;
    ale_d         = 1'b0;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_timeout_d = 1'b0;

    case (state_q)
      S_IDLE, S_T4: begin
        state_d = S_IDLE;
        if (accept) begin
          state_d    = S_T1;
          wr_d       = req_write;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          wait_cnt_d = '0;
          ale_d      = 1'b1;
        end
      end
      S_T1: begin
        state_d = S_T2;
        if (wr_q) begin
          data_oe_d  = 1'b1;
          data_out_d = wdata_q;
        end
      end
      S_T2: begin
        state_d   = S_T3;
        data_oe_d = wr_q;
      end
      S_T3, S_TW: begin
        // A ready target only ends the cycle once the forced waits are done;
        // that check wins over the timeout when both apply.
        if (ready_pin && wait_met) begin
          state_d     = S_T4;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = wr_q ? '0 : Data_in;
        end else if (wait_expired) begin
          state_d       = S_T4;
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
        end else begin
          state_d    = S_TW;
          wait_cnt_d = sat_inc(wait_cnt_q);
          data_oe_d  = wr_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // Single register stage: all bus outputs reflect the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      wait_cnt_q    <= '0;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      data_out_q    <= '0;
      data_oe_q     <= 1'b0;
      ale_q         <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      wr_q          <= wr_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      data_out_q    <= data_out_d;
      data_oe_q     <= data_oe_d;
      ale_q         <= ale_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_timeout_q <= rsp_timeout_d;
      busy_q        <= busy_d;
    end
  end

  assign Direction   = addr_q;
  assign RD_WR       = wr_q;
  assign ale         = ale_q;
  assign Data_out    = data_out_q;
  assign Data_oe     = data_oe_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_timeout = rsp_timeout_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_bus_cycle_ctrl_8088.sv
// ---------------------------------------------------------------------------
// tb_bus_cycle_ctrl_8088
//
// Two controllers share one randomized stimulus stream: instance 0 with the
// default timing (MIN_WAIT=0, TIMEOUT=15) and instance 1 with MIN_WAIT=2,
// TIMEOUT=4. A transaction-level model tracks, per instance, the accept cycle
// of the outstanding request and the cycle offset at which its T4 falls, and
// derives every expected output from those offsets.
// ---------------------------------------------------------------------------
module tb_bus_cycle_ctrl_8088;

  localparam int AW = 20;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic          ready_pin = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [DW-1:0] data_in = '0;

  logic          req_ready_o   [2];
  logic          rsp_valid_o   [2];
  logic [DW-1:0] rsp_rdata_o   [2];
  logic          rsp_timeout_o [2];
  logic [AW-1:0] dir_o         [2];
  logic          ale_o         [2];
  logic          rdwr_o        [2];
  logic [DW-1:0] dout_o        [2];
  logic          doe_o         [2];
  logic          busy_o        [2];

  always #5 clk = ~clk;

  bus_cycle_ctrl_8088 #(.ADDR_W(AW), .DATA_W(DW), .MIN_WAIT(0), .TIMEOUT(15)) u_dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_o[0]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_o[0]), .rsp_rdata(rsp_rdata_o[0]), .rsp_timeout(rsp_timeout_o[0]),
    .Direction(dir_o[0]), .ale(ale_o[0]), .RD_WR(rdwr_o[0]), .Data_out(dout_o[0]),
    .Data_oe(doe_o[0]), .Data_in(data_in), .ready_pin(ready_pin), .busy(busy_o[0])
  );

  bus_cycle_ctrl_8088 #(.ADDR_W(AW), .DATA_W(DW), .MIN_WAIT(2), .TIMEOUT(4)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_o[1]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_o[1]), .rsp_rdata(rsp_rdata_o[1]), .rsp_timeout(rsp_timeout_o[1]),
    .Direction(dir_o[1]), .ale(ale_o[1]), .RD_WR(rdwr_o[1]), .Data_out(dout_o[1]),
    .Data_oe(doe_o[1]), .Data_in(data_in), .ready_pin(ready_pin), .busy(busy_o[1])
  );

  // Reference model state, one slot per instance.
  bit            act [2];   // a request is outstanding
  int            acc [2];   // cycle index of the accepting edge
  int            t4  [2];   // offset of T4 from acc, 0 while undecided
  bit            wr  [2];
  logic [AW-1:0] adr [2];
  logic [DW-1:0] wd  [2];
  logic [DW-1:0] dout[2];
  logic [DW-1:0] rd  [2];
  bit            to  [2];
  int            cyc = 0;

  int n_checks = 0;
  int n_errors = 0;
  int n_to = 0, n_wr = 0, n_rd = 0, n_b2b = 0, n_waited = 0;

  function automatic int min_wait(input int i);
    return (i == 0) ? 0 : 2;
  endfunction

  function automatic int timeout_lim(input int i);
    return (i == 0) ? 15 : 4;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      if (n_errors <= 20)
        $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit exp_ready(input int i);
    return reset && (!act[i] || (t4[i] != 0 && (cyc - acc[i]) == t4[i]));
  endfunction

  task automatic model_clear(input int i);
    act[i] = 0; acc[i] = 0; t4[i] = 0; wr[i] = 0; adr[i] = '0;
    wd[i] = '0; dout[i] = '0; rd[i] = '0; to[i] = 0;
  endtask

  // Advance the model across one rising edge using the inputs presented.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      bit rdy;
      int r;
      int w;
      if (!reset) begin
        model_clear(i);
      end else begin
        rdy = exp_ready(i);
        r = cyc - acc[i];
        if (act[i]) begin
          if (r == 1 && wr[i]) dout[i] = wd[i];
          if (r >= 3 && t4[i] == 0) begin
            w = r - 3;
            if (ready_pin && w >= min_wait(i)) begin
              t4[i] = r + 1; to[i] = 0; rd[i] = wr[i] ? '0 : data_in;
              if (wr[i]) n_wr++; else n_rd++;
              if (w > 0) n_waited++;
            end else if (w == timeout_lim(i)) begin
              t4[i] = r + 1; to[i] = 1; rd[i] = '0;
              n_to++;
            end
          end else if (t4[i] != 0 && r == t4[i]) begin
            act[i] = 0;
          end
        end
        if (rdy && req_valid) begin
          if (act[i] == 0 && t4[i] != 0 && r == t4[i]) n_b2b++;
          act[i] = 1; acc[i] = cyc; t4[i] = 0;
          wr[i] = req_write; adr[i] = req_addr; wd[i] = req_wdata;
        end
      end
    end
    cyc++;
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      int r;
      bit e_vld, e_oe, e_ale;
      r     = cyc - acc[i];
      e_ale = act[i] && r == 1;
      e_vld = act[i] && t4[i] != 0 && r == t4[i];
      e_oe  = act[i] && wr[i] && r >= 2 && !(t4[i] != 0 && r >= t4[i]);
      check($sformatf("u%0d_busy", i),      32'(busy_o[i]),      32'(act[i]));
      check($sformatf("u%0d_req_ready", i), 32'(req_ready_o[i]), 32'(exp_ready(i)));
      check($sformatf("u%0d_ale", i),       32'(ale_o[i]),       32'(e_ale));
      check($sformatf("u%0d_rsp_valid", i), 32'(rsp_valid_o[i]), 32'(e_vld));
      check($sformatf("u%0d_rsp_timeout", i), 32'(rsp_timeout_o[i]), 32'(e_vld ? to[i] : 1'b0));
      check($sformatf("u%0d_data_oe", i),   32'(doe_o[i]),       32'(e_oe));
      check($sformatf("u%0d_direction", i), 32'(dir_o[i]),       32'(adr[i]));
      check($sformatf("u%0d_rd_wr", i),     32'(rdwr_o[i]),      32'(wr[i]));
      check($sformatf("u%0d_data_out", i),  32'(dout_o[i]),      32'(dout[i]));
      if (e_vld)
        check($sformatf("u%0d_rsp_rdata", i), 32'(rsp_rdata_o[i]), 32'(rd[i]));
    end
  endtask

  task automatic drive(input int pv, input int pr, input int pw);
    req_valid = int'($urandom_range(99)) < pv;
    req_write = int'($urandom_range(99)) < pw;
    ready_pin = int'($urandom_range(99)) < pr;
    req_addr  = AW'($urandom);
    req_wdata = DW'($urandom);
    data_in   = DW'($urandom);
  endtask

  task automatic step(input int pv, input int pr, input int pw);
    @(negedge clk);
    check_outputs();
    drive(pv, pr, pw);
    @(posedge clk);
    model_edge();
  endtask

  task automatic run(input int n, input int pv, input int pr, input int pw);
    for (int k = 0; k < n; k++) step(pv, pr, pw);
  endtask

  initial begin
    bit reached;
    for (int i = 0; i < 2; i++) model_clear(i);
    #1 reset = 1'b0;
    run(3, 0, 0, 0);
    #1 reset = 1'b1;

    run(300, 50, 100, 50);   // no target waits
    run(200, 100, 100, 50);  // back-to-back requests
    run(300, 60, 70, 50);    // occasional target waits
    run(150, 100, 0, 50);    // target never ready: aborts
    run(300, 70, 25, 50);    // long wait bursts

    // Pull reset in the middle of a write that sits in Tw.
    reached = 0;
    for (int k = 0; k < 60 && !reached; k++) begin
      step(100, 0, 100);
      reached = act[0] && wr[0] && t4[0] == 0 && (cyc - acc[0]) >= 4;
    end
    check("rst_tw_reached", 32'(reached), 32'd1);
    @(negedge clk);
    check_outputs();
    #2 reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("u%0d_async_oe", i),    32'(doe_o[i]),       32'd0);
      check($sformatf("u%0d_async_busy", i),  32'(busy_o[i]),      32'd0);
      check($sformatf("u%0d_async_ready", i), 32'(req_ready_o[i]), 32'd0);
      check($sformatf("u%0d_async_vld", i),   32'(rsp_valid_o[i]), 32'd0);
      model_clear(i);
    end
    @(posedge clk);
    model_edge();
    run(3, 100, 100, 0);
    #1 reset = 1'b1;

    run(20, 100, 100, 0);    // plain reads after reset release
    run(300, 60, 60, 50);

    check("seen_timeouts",   32'(n_to > 0),     32'd1);
    check("seen_writes",     32'(n_wr > 0),     32'd1);
    check("seen_reads",      32'(n_rd > 0),     32'd1);
    check("seen_b2b",        32'(n_b2b > 0),    32'd1);
    check("seen_waited_rsp", 32'(n_waited > 0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
